// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op to a combinational ALU, repeating 1-bit shifts/rotates SHAMT times
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_cout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_cout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [3:0] OP_PASS = 4'b1000;
  state_t               state, state_nx;
  logic [3:0]           op_r;
  logic [DATA_W-1:0]    a_r, b_r;
  logic [SHAMT_W-1:0]   cnt;
  logic                 accept, shift_op, zero_shamt, last;
  assign shift_op   = req_op[3] & (req_op[2] | req_op[1]);
  assign zero_shamt = req_shamt == '0;
  assign accept     = req_valid & req_ready;
  assign last       = cnt == SHAMT_W'(1);
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  // ALU inputs are forced quiet outside EXEC so nothing downstream toggles
  assign alu_a  = state == EXEC ? a_r : '0;
  assign alu_b  = state == EXEC ? b_r : '0;
  assign alu_op = state == EXEC ? op_r : OP_PASS;
  always_ff @(posedge CLK)
    if (!RSTn) state <= IDLE;
    else       state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && req_valid)      state_nx = EXEC;
    else if (state == EXEC && last)      state_nx = DONE;
    else if (state == DONE && rsp_ready) state_nx = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      op_r      <= OP_PASS;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      rsp_c     <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= shift_op && zero_shamt ? OP_PASS : req_op;
        a_r  <= req_a;
        b_r  <= req_b;
        cnt  <= shift_op && !zero_shamt ? req_shamt : SHAMT_W'(1);
      end
      // each pass feeds the result back as A for the next 1-bit step
      if (state == EXEC) begin
        a_r <= alu_c;
        cnt <= cnt - SHAMT_W'(1);
        if (last) begin
          rsp_c     <= alu_c;
          rsp_cout  <= op_r[3:1] == 3'b000 ? alu_cout : 1'b0;
          rsp_valid <= 1'b1;
        end
      end
      if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural 1-bit-step ALU attached
module tb_alu_op_sequencer;
  logic        CLK = 1'b0, RSTn = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_shamt = '0;
  logic        req_ready, rsp_valid, rsp_cout, busy, alu_cout;
  logic [31:0] rsp_c, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  int          errors = 0, checks = 0;
  logic [32:0] exp_q[$];
  always #5 CLK = ~CLK;
  alu_op_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_cout(rsp_cout), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_c(alu_c), .alu_cout(alu_cout), .busy(busy)
  );
  // single-step ALU; Cout is deliberately 1 on non-arithmetic ops to expose masking faults
  always_comb begin
    alu_c    = alu_a;
    alu_cout = 1'b1;
    case (alu_op)
      4'b0000: {alu_cout, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: begin alu_c = alu_a - alu_b; alu_cout = alu_a < alu_b; end
      4'b0010: alu_c = alu_a & alu_b;
      4'b0011: alu_c = alu_a | alu_b;
      4'b0100: alu_c = alu_a ^ alu_b;
      4'b1010: alu_c = alu_a >> 1;
      4'b1011: alu_c = {alu_a[31], alu_a[31:1]};
      4'b1100: alu_c = {alu_a[30:0], alu_a[31]};
      4'b1101: alu_c = alu_a << 1;
      4'b1110: alu_c = {alu_a[0], alu_a[31:1]};
      default: alu_c = alu_a;
    endcase
  end
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    logic [32:0] r;
    r = {1'b0, a};
    case (op)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0001: r = {a < b, a - b};
      4'b0100: r = {1'b0, a ^ b};
      4'b1010: r = {1'b0, a >> sh};
      4'b1100: r = {1'b0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      4'b1101: r = {1'b0, a << sh};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask
  always @(negedge CLK)
    if (RSTn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_c", rsp_c, e[31:0]);
        check("rsp_cout", rsp_cout, e[32]);
      end
    end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    check("req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
    exp_q.push_back(model(op, a, b, sh));
    @(posedge CLK); #1 req_valid = 1'b0;
  endtask
  task automatic await_rsp(input logic [3:0] op, input logic [4:0] sh);
    int n = 0;
    logic is_shift;
    is_shift = op[3] & (op[2] | op[1]);
    do begin
      @(negedge CLK); n++;
      if (!rsp_valid) begin
        check("exec_op", alu_op, is_shift && sh == 0 ? 4'b1000 : op);
        check("busy", busy, 1);
      end
    end while (!rsp_valid && n < 100);
    check("latency", n, (is_shift && sh != 0 ? sh : 1) + 1);
  endtask
  task automatic run(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    issue(op, a, b, sh);
    await_rsp(op, sh);
  endtask
  initial begin
    logic [31:0] held;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_op", alu_op, 4'b1000);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    run(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    run(4'b0001, 32'h0000_0005, 32'h0000_0003, 5'd9);
    run(4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
    run(4'b1101, 32'h0000_0001, 32'h0, 5'd4);
    run(4'b1101, 32'h0000_0001, 32'h0, 5'd0);
    run(4'b1100, 32'h8000_0001, 32'h0, 5'd7);
    run(4'b1010, 32'h8000_0000, 32'h0, 5'd31);
    run(4'b0001, 32'h0000_0003, 32'h0000_0005, 5'd0);
    @(negedge CLK);
    check("idle_alu_op", alu_op, 4'b1000);
    check("idle_alu_a", alu_a, 0);
    // backpressure: response held, new request ignored while DONE
    @(posedge CLK); #1 rsp_ready = 1'b0;
    run(4'b0000, 32'h1234_5678, 32'h1111_1111, 5'd0);
    held = rsp_c;
    req_valid = 1'b1; req_op = 4'b0100; req_a = 32'hDEAD_BEEF; req_b = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_valid", rsp_valid, 1);
      check("bp_c", rsp_c, held);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge CLK); #1 rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_no_accept", busy, 0);
    // back-to-back: second request present at the handshake edge
    issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0);
    await_rsp(4'b0000, 5'd0);
    req_valid = 1'b1; req_op = 4'b0100; req_a = 32'hAAAA_0000; req_b = 32'h0000_5555; req_shamt = 5'd0;
    @(negedge CLK);
    check("b2b_ready", req_ready, 1);
    exp_q.push_back(model(4'b0100, 32'hAAAA_0000, 32'h0000_5555, 5'd0));
    @(posedge CLK); #1 req_valid = 1'b0;
    await_rsp(4'b0100, 5'd0);
    // reset in the middle of a long shift drops it
    issue(4'b1101, 32'h0000_0003, 32'h0, 5'd20);
    repeat (5) @(negedge CLK);
    check("mid_busy", busy, 1);
    RSTn = 1'b0;
    void'(exp_q.pop_back());
    @(negedge CLK);
    check("mr_req_ready", req_ready, 1);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_alu_op", alu_op, 4'b1000);
    check("mr_busy", busy, 0);
    RSTn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      if (rsp_valid) check("mr_spurious", rsp_valid, 0);
    end
    run(4'b0000, 32'h0000_0010, 32'h0000_0020, 5'd3);
    @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
